// File: rtl/clint_pkg.sv
// Shared register-map offsets, time type and byte-strobe merge helper for the
// multi-hart core-local interruptor.
package clint_pkg;

    localparam logic [31:0] MSIP_OFF     = 32'h0000_0000;
    localparam logic [31:0] MTIMECMP_OFF = 32'h0000_4000;
    localparam logic [31:0] PRESCALE_OFF = 32'h0000_BFF0;
    localparam logic [31:0] MTIME_OFF    = 32'h0000_BFF8;

    typedef logic [63:0] mtime_t;

    function automatic logic [31:0] strb_merge(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  strb
    );
        logic [31:0] r;
        r = old_v;
        for (int unsigned b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/clint_cmp.sv
// One hart's MTIMECMP register with byte-strobed lo/hi writes and a
// registered unsigned MTIME >= MTIMECMP comparator.
module clint_cmp
    import clint_pkg::*;
(
    input  logic        clk,
    input  logic        resetb,
    input  mtime_t      mtime,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output mtime_t      mtimecmp,
    output logic        timer_irq
);

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            mtimecmp  <= '1;
            timer_irq <= 1'b0;
        end else begin
            if (wr_lo) mtimecmp[31:0]  <= strb_merge(mtimecmp[31:0], wdata, wstrb);
            if (wr_hi) mtimecmp[63:32] <= strb_merge(mtimecmp[63:32], wdata, wstrb);
            timer_irq <= (mtime >= mtimecmp);
        end
    end

endmodule

// File: rtl/clint_mh.sv
// Multi-hart CLINT: prescaled 64-bit MTIME, per-hart MTIMECMP/MSIP, single-cycle
// write port and one-cycle-latency read port with a tear-free MTIME hi shadow.
module clint_mh
    import clint_pkg::*;
#(
    parameter int unsigned NHART = 2,
    parameter logic [31:0] BASE  = 32'h0200_0000,
    parameter int unsigned PSC_W = 16
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             timer_en,
    input  logic             wready,
    output logic             wvalid,
    input  logic [31:0]      waddr,
    input  logic [31:0]      wdata,
    input  logic [3:0]       wstrb,
    input  logic             rready,
    output logic             rvalid,
    input  logic [31:0]      raddr,
    output logic             rresp,
    output logic [31:0]      rdata,
    output logic [NHART-1:0] timer_irq,
    output logic [NHART-1:0] sw_irq,
    output logic [NHART-1:0] ex_irq
);

    localparam logic [31:0] A_PSC   = BASE + PRESCALE_OFF;
    localparam logic [31:0] A_MT_LO = BASE + MTIME_OFF;
    localparam logic [31:0] A_MT_HI = BASE + MTIME_OFF + 32'd4;

    function automatic logic [31:0] msip_addr(input int unsigned h);
        return BASE + MSIP_OFF + 32'(4 * h);
    endfunction

    function automatic logic [31:0] cmp_addr(input int unsigned h, input logic hi);
        return BASE + MTIMECMP_OFF + 32'(8 * h) + (hi ? 32'd4 : 32'd0);
    endfunction

    logic [NHART-1:0] wr_msip, wr_cmp_lo, wr_cmp_hi;
    logic             wr_psc, wr_mt_lo, wr_mt_hi;
    logic [PSC_W-1:0] prescale, psc_cnt;
    logic             tick;
    mtime_t           mtime, mtime_nxt;
    logic [31:0]      shadow, rd_val;
    mtime_t           cmp_val [NHART];

    assign wvalid = 1'b1;
    assign rvalid = 1'b1;

    always_comb begin
        wr_msip   = '0;
        wr_cmp_lo = '0;
        wr_cmp_hi = '0;
        for (int unsigned h = 0; h < NHART; h++) begin
            wr_msip[h]   = wready && (waddr == msip_addr(h));
            wr_cmp_lo[h] = wready && (waddr == cmp_addr(h, 1'b0));
            wr_cmp_hi[h] = wready && (waddr == cmp_addr(h, 1'b1));
        end
        wr_psc   = wready && (waddr == A_PSC);
        wr_mt_lo = wready && (waddr == A_MT_LO);
        wr_mt_hi = wready && (waddr == A_MT_HI);
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            sw_irq <= '0;
            ex_irq <= '0;
        end else begin
            for (int unsigned h = 0; h < NHART; h++) begin
                if (wr_msip[h]) begin
                    if (wstrb[0]) sw_irq[h] <= wdata[0];
                    if (wstrb[2]) ex_irq[h] <= wdata[16];
                end
            end
        end
    end

    // Tick is judged on the current count even in a PRESCALE-write cycle;
    // the write only forces the counter back to zero.
    assign tick = timer_en && (psc_cnt == prescale);

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            prescale <= '0;
            psc_cnt  <= '0;
        end else if (wr_psc) begin
            prescale <= PSC_W'(strb_merge(32'(prescale), wdata, wstrb));
            psc_cnt  <= '0;
        end else if (timer_en) begin
            psc_cnt  <= tick ? '0 : psc_cnt + PSC_W'(1);
        end
    end

    // A software write to either half wins over the tick increment.
    always_comb begin
        mtime_nxt = mtime;
        if (wr_mt_lo) begin
            mtime_nxt[31:0] = strb_merge(mtime[31:0], wdata, wstrb);
        end else if (wr_mt_hi) begin
            mtime_nxt[63:32] = strb_merge(mtime[63:32], wdata, wstrb);
        end else if (tick) begin
            mtime_nxt = mtime + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            mtime <= '0;
        end else begin
            mtime <= mtime_nxt;
        end
    end

    for (genvar h = 0; h < NHART; h++) begin : g_cmp
        clint_cmp u_cmp (
            .clk       (clk),
            .resetb    (resetb),
            .mtime     (mtime),
            .wr_lo     (wr_cmp_lo[h]),
            .wr_hi     (wr_cmp_hi[h]),
            .wdata     (wdata),
            .wstrb     (wstrb),
            .mtimecmp  (cmp_val[h]),
            .timer_irq (timer_irq[h])
        );
    end

    always_comb begin
        rd_val = '0;
        for (int unsigned h = 0; h < NHART; h++) begin
            if (raddr == msip_addr(h))       rd_val = {15'h0, ex_irq[h], 15'h0, sw_irq[h]};
            if (raddr == cmp_addr(h, 1'b0))  rd_val = cmp_val[h][31:0];
            if (raddr == cmp_addr(h, 1'b1))  rd_val = cmp_val[h][63:32];
        end
        if (raddr == A_PSC)   rd_val = 32'(prescale);
        if (raddr == A_MT_LO) rd_val = mtime[31:0];
        if (raddr == A_MT_HI) rd_val = shadow;
    end

    // Read data is sampled from pre-edge state, so a same-cycle write is not seen.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            rresp  <= 1'b0;
            rdata  <= '0;
            shadow <= '0;
        end else begin
            rresp <= rready;
            rdata <= rready ? rd_val : '0;
            if (rready && (raddr == A_MT_LO)) shadow <= mtime[63:32];
        end
    end

endmodule

// File: doc/clint_mh.md
CLINT_MH -- requirements
Module: clint_mh

Interface
REQ-001 SHALL have parameter NHART, default 2, meaning number of harts served (1..8).
REQ-002 SHALL have parameter BASE, default 32'h0200_0000, meaning the register-map base address.
REQ-003 SHALL have parameter PSC_W, default 16, meaning prescaler width in bits.
REQ-004 clk  in  1  clock.
REQ-005 resetb  in  1  asynchronous, active-low reset.
REQ-006 timer_en  in  1  global count enable.
REQ-007 wready  in  1  write request; wvalid  out  1  write accept.
REQ-008 waddr  in  32, wdata  in  32, wstrb  in  4  write address, data and byte strobes.
REQ-009 rready  in  1  read request; rvalid  out  1  read accept.
REQ-010 raddr  in  32  read address; rresp  out  1  read data valid; rdata  out  32  read data.
REQ-011 timer_irq, sw_irq, ex_irq  out  NHART each  per-hart interrupt lines, bit h = hart h.

Function
REQ-012 The map SHALL be: MSIP[h] at BASE+4h, MTIMECMP[h] lo/hi at BASE+0x4000+8h / +4, PRESCALE at BASE+0xBFF0, MTIME lo/hi at BASE+0xBFF8 / BASE+0xBFFC; decode is full 32-bit equality.
REQ-013 wvalid and rvalid SHALL be tied to 1; every request is accepted in the cycle it is presented.
REQ-014 Writes SHALL honour wstrb per byte; unstrobed bytes keep their value; writes to unmapped addresses are ignored.
REQ-015 MSIP[h] writes SHALL update sw_irq[h] from wdata[0] (strobe 0) and ex_irq[h] from wdata[16] (strobe 2), effective the next cycle.
REQ-016 The prescaler counter SHALL increment while timer_en=1, emit a tick and wrap to 0 when it equals PRESCALE, and hold while timer_en=0; PRESCALE=0 means a tick every cycle.
REQ-017 Any write to PRESCALE SHALL clear the prescaler counter the same cycle.
REQ-018 MTIME SHALL increment by 1 on each tick, wrapping from 2^64-1 to 0.
REQ-019 A write to either MTIME half SHALL take priority over a tick in the same cycle: the written half gets the new bytes, the other half holds, and there is no increment that cycle.
REQ-020 timer_irq[h] SHALL be registered: 1 the cycle after (MTIME >= MTIMECMP[h]), unsigned 64-bit, else 0.
REQ-021 A read SHALL set rresp=1 and rdata valid exactly one cycle after rready=1; rresp=0 otherwise.
REQ-022 Reading MTIME lo SHALL also latch MTIME[63:32] into a shadow; reading MTIME hi SHALL return the shadow, giving a tear-free 64-bit read when lo is read first.
REQ-023 MSIP[h] SHALL read as {15'h0, ex_irq[h], 15'h0, sw_irq[h]}; PRESCALE SHALL read zero-extended; unmapped reads SHALL return 32'h0.
REQ-024 A same-cycle read and write to one address SHALL return the pre-write value.

Reset
REQ-025 Asynchronous reset SHALL set MTIME=0, shadow=0, prescaler counter=0, PRESCALE=0, all MTIMECMP=64'hFFFF_FFFF_FFFF_FFFF, sw_irq=ex_irq=timer_irq=0, rresp=0, rdata=0.
REQ-026 Reset asserted mid-read SHALL drop rresp to 0 immediately with no later response.

Structure
REQ-027 Package clint_pkg SHALL hold the offset constants (MSIP_OFF, MTIMECMP_OFF, PRESCALE_OFF, MTIME_OFF) and the 64-bit time type.
REQ-028 Sub-module clint_cmp SHALL hold one hart's MTIMECMP register, strobed write and registered compare; it is instantiated NHART times by generate.

Verification
REQ-029 After reset with timer_en=1 and PRESCALE=0, poll MTIME lo at cycle 10 -> counts by 1 per cycle; all timer_irq=0.
REQ-030 PRESCALE=3 -> MTIME increments every 4th enabled cycle; timer_en low for 5 cycles -> MTIME and prescaler hold.
REQ-031 MTIMECMP[1]=0x20, MTIME=0x1E -> timer_irq[1] rises the cycle after MTIME=0x20, timer_irq[0] stays 0; then MTIMECMP[1] hi=1 -> timer_irq[1] drops.
REQ-032 MTIME=0x0000_0000_FFFF_FFFF, then read lo then hi -> lo/hi pair is consistent (hi=1 only if lo was read after the carry).
REQ-033 Write MSIP[1]=0x0001_0001 with wstrb=4'b0001 -> sw_irq[1]=1, ex_irq[1]=0; write with wstrb=4'b0100 -> ex_irq[1]=1.
REQ-034 Write MTIME lo in the same cycle as a tick -> written value held, no increment; unmapped read -> rdata=0, rresp=1 one cycle later.
